add_not_alu: RTL and testbench



---
 rtl/add_not_pkg.sv | 8 +
 rtl/full_adder.sv | 13 +
 rtl/add_not_alu.sv | 54 +++++
 tb/tb_add_not_alu.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/add_not_pkg.sv
// Shared constants for the add/NOT ALU slice: select encodings and default width.
package add_not_pkg;

  localparam logic        SEL_ADD       = 1'b0;
  localparam logic        SEL_NOT       = 1'b1;
  localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; chained by add_not_alu into a ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_not_alu.sv
// Two-function ALU slice: ripple-carry add with carry-out, or bitwise NOT of a.
// The result and carry are registered; reset clears both asynchronously.
module add_not_alu
  import add_not_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select,
  output logic [WIDTH-1:0] mux,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] next_mux;
  logic             next_cout;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (add_res[i]),
      .cout (carry[i+1])
    );
  end

  // NOT path never looks at b, so an unknown b cannot reach the result.
  always_comb begin
    next_mux  = add_res;
    next_cout = carry[WIDTH];
    if (select == SEL_NOT) begin
      next_mux  = ~a;
      next_cout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux  <= '0;
      cout <= 1'b0;
    end else begin
      mux  <= next_mux;
      cout <= next_cout;
    end
  end

endmodule

// File: tb/tb_add_not_alu.sv
// Self-checking bench for add_not_alu: directed table, select toggling,
// reset behaviour and randomized traffic with asynchronous reset pulses.
module tb_add_not_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         select;
  logic [W-1:0] mux;
  logic         cout;

  add_not_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .select (select),
    .mux    (mux),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] mux;
    logic         cout;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] em;
    logic         ec;
  } vec_t;

  exp_t        sbq[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vs);
    logic [W:0] s;
    s = {1'b0, va} + {1'b0, vb};
    if (vs) return {~va, 1'b0};
    return {s[W-1:0], s[W]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got_m, input logic got_c,
                       input logic [W-1:0] exp_m, input logic exp_c);
    total++;
    if (got_m === exp_m && got_c === exp_c) passed++;
    else $display("FAIL %s: got mux=%h cout=%b, expected mux=%h cout=%b",
                  name, got_m, got_c, exp_m, exp_c);
  endtask

  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                       input logic [W-1:0] em, input logic ec);
    @(negedge clk);
    a      = va;
    b      = vb;
    select = vs;
    sbq.push_back({em, ec});
  endtask

  task automatic collect(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got mux=%h cout=%b", name, mux, cout);
    end else begin
      e = sbq.pop_front();
      check(name, mux, cout, e.mux, e.cout);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         tbl[8];
    logic [W-1:0] ra, rb;
    logic         rs;
    exp_t         e;

    tbl[0] = '{32'h0000_0000, 32'h1111_1111, 1'b0, 32'h1111_1111, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h1111_1111, 1'b1, 32'hFFFF_FFFF, 1'b0};
    tbl[2] = '{32'hA5A5_0F0F, 32'h1111_1111, 1'b1, 32'h5A5A_F0F0, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1};
    tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    tbl[6] = '{32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1, 32'hF0F0_F0F0, 1'b0};
    tbl[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};

    // Reset held with the clock running: outputs stay zero.
    rst    = 1'b1;
    a      = 32'h1234_5678;
    b      = 32'h0000_0100;
    select = 1'b0;
    #1;
    check("reset_initial", mux, cout, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", mux, cout, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sbq.push_back({32'h1234_5778, 1'b0});
    collect("reset_release_load");

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].em, tbl[i].ec);
      collect($sformatf("table_%0d", i));
    end

    // Select flips on every cycle with operands that overflow under add.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
      else            drive(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0);
      collect($sformatf("toggle_%0d", i));
    end

    // Mid-stream reset: zeros at once, next edge loads the current inputs.
    drive(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEF0, 1'b0);
    collect("pre_reset");
    #1 rst = 1'b1;
    #1 check("midreset_zero", mux, cout, '0, 1'b0);
    #1 rst = 1'b0;
    #1 check("midreset_hold", mux, cout, '0, 1'b0);
    drive(32'h0000_0003, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 1'b1);
    collect("post_reset_load");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rs);
      drive(ra, rb, rs, e.mux, e.cout);
      collect($sformatf("random_%0d", i));
      if ($urandom_range(0, 19) == 0) begin
        #1 rst = 1'b1;
        #1 check($sformatf("random_rst_%0d", i), mux, cout, '0, 1'b0);
        #1 rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
